// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

  localparam int UART_SRC_NUM = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_sched_state;

  localparam logic [1:0] SRC_GAME_STATE = 2'd0;
  localparam logic [1:0] SRC_GLOVES     = 2'd1;
  localparam logic [1:0] SRC_MOUSE      = 2'd2;
  localparam logic [1:0] SRC_SCORE      = 2'd3;

  // Next round-robin start point after serving idx.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter4.sv
// Four-way combinational round-robin arbiter: the request at ptr has top
// priority, then ptr+1, ptr+2, ptr+3 (mod 4).
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [1:0] idx;

  // Scan from the furthest offset back to ptr so the nearest request wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    idx         = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Change-driven UART transmit scheduler: sends each status byte when it
// differs from the last value sent, round-robin, with a minimum gap of
// GAP_CYCLES between write strobes. Define TX_REFRESH_EN to add a periodic
// re-send of all four bytes every REFRESH_CYCLES cycles.
//
// state | meaning
// IDLE  | waiting for a pending source and tx_full low
// SEND  | wr_uart high for one cycle, shadow updated
// GAP   | enforcing the inter-byte spacing
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES     = 16,
  parameter int REFRESH_CYCLES = 650_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_game_state_sel,
  input  logic [7:0] data_gloves_control,
  input  logic [7:0] data_mouse_control,
  input  logic [7:0] data_score_control,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [3:0] pending,
  output logic       sched_busy
);

  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  tx_sched_state          state_q, state_d;
  logic [UART_SRC_NUM-1:0][7:0] src_data;
  logic [UART_SRC_NUM-1:0][7:0] shadow_q, shadow_d;
  logic [3:0]             pending_q, pending_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [1:0]             sel_idx_q, sel_idx_d;
  logic [7:0]             w_data_q, w_data_d;
  logic                   wr_uart_q, wr_uart_d;
  logic                   busy_q, busy_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   grant_valid;
  logic [1:0]             grant_idx;
  logic                   refresh_tick;

  assign src_data[SRC_GAME_STATE] = data_game_state_sel;
  assign src_data[SRC_GLOVES]     = data_gloves_control;
  assign src_data[SRC_MOUSE]      = data_mouse_control;
  assign src_data[SRC_SCORE]      = data_score_control;

`ifdef TX_REFRESH_EN
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  logic [REF_W-1:0] ref_cnt_q;

  assign refresh_tick = (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));

  // Free-running refresh period counter, independent of the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ref_cnt_q <= '0;
    else     ref_cnt_q <= refresh_tick ? '0 : ref_cnt_q + 1'b1;
  end
`else
  // Refresh disabled: the tick is never true (REFRESH_CYCLES is positive).
  assign refresh_tick = (REFRESH_CYCLES < 0);
`endif

  rr_arbiter4 u_arb (
    .req         (pending_q),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next-state, pending tracking and output decode.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    rr_ptr_d  = rr_ptr_q;
    sel_idx_d = sel_idx_q;
    w_data_d  = w_data_q;
    gap_cnt_d = gap_cnt_q;
    wr_uart_d = 1'b0;
    for (int i = 0; i < UART_SRC_NUM; i++) begin
      pending_d[i] = pending_q[i] | (src_data[i] != shadow_q[i]) | refresh_tick;
    end

    case (state_q)
      IDLE: begin
        if (grant_valid && !tx_full) begin
          w_data_d  = src_data[grant_idx];
          sel_idx_d = grant_idx;
          wr_uart_d = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        shadow_d[sel_idx_q]  = w_data_q;
        // A change arriving while the byte goes out keeps the flag set.
        pending_d[sel_idx_q] = (src_data[sel_idx_q] != w_data_q) | refresh_tick;
        rr_ptr_d             = rr_next(sel_idx_q);
        gap_cnt_d            = '0;
        state_d              = GAP;
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (int'(gap_cnt_q) + 1 >= GAP_CYCLES - 2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      sel_idx_q <= '0;
      w_data_q  <= 8'h00;
      wr_uart_q <= 1'b0;
      busy_q    <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_idx_q <= sel_idx_d;
      w_data_q  <= w_data_d;
      wr_uart_q <= wr_uart_d;
      busy_q    <= busy_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign w_data     = w_data_q;
  assign wr_uart    = wr_uart_q;
  assign pending    = pending_q;
  assign sched_busy = busy_q;

endmodule
